// File: rtl/alu8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu8_pkg
//  Purpose  : Shared types and constants for the nRISC 8-bit sequential ALU
//             controller (nibble width, compare op code, op encodings and
//             the controller state enumeration).
//  Config   : none
//  Revision : 1.0  initial release
// ============================================================================
package alu8_pkg;

    localparam int         NIB_W    = 4;
    localparam logic [1:0] CMP_OP   = 2'b11;

    // Op encodings as understood by the shared nibble ALU slice.
    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_and = 2'b01;
    localparam logic [1:0] c_op_or  = 2'b10;
    localparam logic [1:0] c_op_cmp = CMP_OP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : alu8_pkg
`default_nettype wire

// File: rtl/alu8_seq_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : alu8_seq_fsm
//  Purpose  : Pass sequencer for the two-pass (high nibble, low nibble)
//             8-bit operation. Holds the state register, decides the next
//             pass and decodes busy/done.
//  Ports    : clk, rst         - clock, synchronous active-high reset
//             i_start          - operation request
//             i_early_exit     - skip the low pass (valid in HIGH only)
//             o_state          - current state
//             o_accept         - start accepted this cycle (latch operands)
//             o_busy, o_done   - HIGH/LOW indicator, DONE pulse
//  Revision : 1.0  initial release
// ============================================================================
module alu8_seq_fsm
    import alu8_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_start,
    input  logic   i_early_exit,
    output state_t o_state,
    output logic   o_accept,
    output logic   o_busy,
    output logic   o_done
);

    state_t r_state;
    state_t w_next;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? HIGH : IDLE;
            HIGH:    w_next = i_early_exit ? DONE : LOW;
            LOW:     w_next = DONE;
            DONE:    w_next = i_start ? HIGH : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode; start is only honoured when no operation is in flight.
    always_comb begin
        o_busy   = (r_state == HIGH) || (r_state == LOW);
        o_done   = (r_state == DONE);
        o_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
    end

    assign o_state = r_state;

endmodule : alu8_seq_fsm
`default_nettype wire

// File: rtl/alu8_nibble_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu8_nibble_seq
//  Purpose  : Runs each 8-bit ALU operation as two passes through an external
//             combinational 4-bit nibble ALU slice (high nibble, then low
//             nibble) and presents a registered word result with eq/zero.
//  Ports    : clock, reset            - clock, synchronous active-high reset
//             start, op, cin0, a, b   - request, op select, cascade-init,
//                                       operands (latched on acceptance)
//             busy, done              - in-flight flag, one-cycle done pulse
//             result, eq, zero        - registered word result and flags
//             nib_a, nib_b, nib_sel,
//             nib_cin                 - drive to the nibble slice
//             nib_f, nib_eq, nib_nz   - slice result, equality, nonzero
//  Config   : ALU8_SEQ_CMP_EARLY_EN - compare ops whose high nibbles differ
//             finish after the high pass (2-cycle latency).
//  Revision : 1.0  initial release
// ============================================================================
module alu8_nibble_seq #(
    parameter int         NIB_W  = 4,
    parameter logic [1:0] CMP_OP = 2'b11
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic               cin0,
    input  logic [2*NIB_W-1:0] a,
    input  logic [2*NIB_W-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [2*NIB_W-1:0] result,
    output logic               eq,
    output logic               zero,
    output logic [NIB_W-1:0]   nib_a,
    output logic [NIB_W-1:0]   nib_b,
    output logic [1:0]         nib_sel,
    output logic               nib_cin,
    input  logic [NIB_W-1:0]   nib_f,
    input  logic               nib_eq,
    input  logic               nib_nz
);
    import alu8_pkg::*;

    localparam int c_word_w = 2 * NIB_W;

`ifdef ALU8_SEQ_CMP_EARLY_EN
    localparam bit c_early_en = 1'b1;
`else
    localparam bit c_early_en = 1'b0;
`endif

    state_t              w_state;
    logic                w_accept;
    logic                w_early_exit;

    logic [c_word_w-1:0] r_a;
    logic [c_word_w-1:0] r_b;
    logic [1:0]          r_op;
    logic                r_cin;
    logic [NIB_W-1:0]    r_f_hi;
    logic                r_eq_hi;
    logic                r_nz_hi;
    logic [c_word_w-1:0] r_result;
    logic                r_eq;
    logic                r_zero;

    // A compare that already differs in the high nibble cannot become equal.
    assign w_early_exit = c_early_en && (r_op == CMP_OP) && !nib_eq;

    alu8_seq_fsm u_fsm (
        .clk          (clock),
        .rst          (reset),
        .i_start      (start),
        .i_early_exit (w_early_exit),
        .o_state      (w_state),
        .o_accept     (w_accept),
        .o_busy       (busy),
        .o_done       (done)
    );

    // Slice drive: operands only during the two passes, quiet otherwise.
    always_comb begin
        nib_a   = '0;
        nib_b   = '0;
        nib_sel = '0;
        nib_cin = 1'b0;
        case (w_state)
            HIGH: begin
                nib_a   = r_a[c_word_w-1:NIB_W];
                nib_b   = r_b[c_word_w-1:NIB_W];
                nib_sel = r_op;
                nib_cin = r_cin;
            end
            LOW: begin
                nib_a   = r_a[NIB_W-1:0];
                nib_b   = r_b[NIB_W-1:0];
                nib_sel = r_op;
                nib_cin = r_cin;
            end
            default: ;
        endcase
    end

    // Operand latches, high-pass capture and word result. The word result is
    // written on the edge that enters DONE, so it is valid with done and
    // holds through the following operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_cin    <= 1'b0;
            r_f_hi   <= '0;
            r_eq_hi  <= 1'b0;
            r_nz_hi  <= 1'b0;
            r_result <= '0;
            r_eq     <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op;
                r_cin <= cin0;
            end
            case (w_state)
                HIGH: begin
                    r_f_hi  <= nib_f;
                    r_eq_hi <= nib_eq;
                    r_nz_hi <= nib_nz;
                    if (w_early_exit) begin
                        r_result <= {nib_f, {NIB_W{1'b0}}};
                        r_eq     <= 1'b0;
                        r_zero   <= ~nib_nz;
                    end
                end
                LOW: begin
                    r_result <= {r_f_hi, nib_f};
                    r_eq     <= r_eq_hi & nib_eq;
                    r_zero   <= ~(r_nz_hi | nib_nz);
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign eq     = r_eq;
    assign zero   = r_zero;

endmodule : alu8_nibble_seq
`default_nettype wire

// File: tb/tb_alu8_nibble_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu8_nibble_seq
//  Purpose  : Self-checking bench for alu8_nibble_seq with a behavioural
//             nibble-slice model, directed vector table, random operations
//             and hand-written multi-cycle sequences.
//  Config   : follows ALU8_SEQ_CMP_EARLY_EN like the design
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu8_nibble_seq;

`ifdef ALU8_SEQ_CMP_EARLY_EN
    localparam bit c_early = 1'b1;
`else
    localparam bit c_early = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op    = 2'b00;
    logic       cin0  = 1'b0;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;
    logic       busy, done, eq, zero;
    logic [7:0] result;
    logic [3:0] nib_a, nib_b, nib_f;
    logic [1:0] nib_sel;
    logic       nib_cin, nib_eq, nib_nz;
    logic       force_zero = 1'b0;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] prev_result = 8'h00;

    always #5 clock = ~clock;

    alu8_nibble_seq dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .cin0    (cin0),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .eq      (eq),
        .zero    (zero),
        .nib_a   (nib_a),
        .nib_b   (nib_b),
        .nib_sel (nib_sel),
        .nib_cin (nib_cin),
        .nib_f   (nib_f),
        .nib_eq  (nib_eq),
        .nib_nz  (nib_nz)
    );

    // Nibble slice: 00 add with carry-in, 01 and, 10 or, 11 compare-subtract.
    function automatic logic [3:0] slice_f(input logic [3:0] x, input logic [3:0] y,
                                           input logic [1:0] s, input logic c);
        case (s)
            2'b00:   return x + y + {3'b000, c};
            2'b01:   return x & y;
            2'b10:   return x | y;
            default: return x + ~y + {3'b000, c};
        endcase
    endfunction

    always_comb begin
        nib_f  = force_zero ? 4'h0 : slice_f(nib_a, nib_b, nib_sel, nib_cin);
        nib_eq = (nib_a == nib_b);
        nib_nz = |nib_f;
    end

    // Word-level reference for one operation.
    function automatic void ref_model(input logic [7:0] xa, input logic [7:0] xb,
                                      input logic [1:0] xop, input logic xc, input logic fz,
                                      output logic [7:0] r, output logic e, output logic z,
                                      output int lat);
        logic [3:0] hi, lo;
        hi = fz ? 4'h0 : slice_f(xa[7:4], xb[7:4], xop, xc);
        lo = fz ? 4'h0 : slice_f(xa[3:0], xb[3:0], xop, xc);
        if (c_early && xop == 2'b11 && xa[7:4] != xb[7:4]) begin
            r = {hi, 4'h0}; e = 1'b0; z = (hi == 4'h0); lat = 2;
        end else begin
            r = {hi, lo}; e = (xa == xb); z = ({hi, lo} == 8'h00); lat = 3;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One operation from an idle cycle to its done pulse.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] xop,
                          input logic xc, input logic [7:0] er, input logic ee,
                          input logic ez, input int elat);
        int lat;
        @(negedge clock);
        a = xa; b = xb; op = xop; cin0 = xc; start = 1'b1;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (i == 1) begin
                check("high_nib_a", {28'd0, nib_a}, {28'd0, xa[7:4]});
                check("high_nib_b", {28'd0, nib_b}, {28'd0, xb[7:4]});
                check("high_sel", {30'd0, nib_sel}, {30'd0, xop});
                check("busy_high", {31'd0, busy}, 32'd1);
                check("result_hold", {24'd0, result}, {24'd0, prev_result});
            end
            if (i == 2 && elat == 3) begin
                check("low_nib_a", {28'd0, nib_a}, {28'd0, xa[3:0]});
                check("low_nib_b", {28'd0, nib_b}, {28'd0, xb[3:0]});
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, elat);
        check("result", {24'd0, result}, {24'd0, er});
        check("eq", {31'd0, eq}, {31'd0, ee});
        check("zero", {31'd0, zero}, {31'd0, ez});
        check("done_nib_idle", {28'd0, nib_a}, 32'd0);
        prev_result = er;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       cin;
        logic       fz;
        logic [7:0] r;
        logic       e;
        logic       z;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         ndone;
        logic [7:0] ra, rb, rr;
        logic [1:0] rop;
        logic       rc, rfz, re, rz;
        int         rlat;

        vecs[0] = '{8'h3C, 8'h3C, 2'b11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[1] = '{8'h5A, 8'h7A, 2'b11, 1'b1, 1'b0, 8'hE0, 1'b0, 1'b0};
        vecs[2] = '{8'h12, 8'h34, 2'b00, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[3] = '{8'h9F, 8'h9F, 2'b00, 1'b1, 1'b0, 8'h3F, 1'b1, 1'b0};
        vecs[4] = '{8'hF0, 8'h0F, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5] = '{8'hA5, 8'h5A, 2'b10, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h77, 8'h77, 2'b00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h80, 8'h00, 2'b11, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0};

        // Reset held for two cycles.
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_eq", {31'd0, eq}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_nib_a", {28'd0, nib_a}, 32'd0);

        // Directed vector table.
        for (int v = 0; v < 8; v++) begin
            force_zero = vecs[v].fz;
            run_op(vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].cin, vecs[v].r, vecs[v].e,
                   vecs[v].z,
                   (c_early && vecs[v].op == 2'b11 && vecs[v].a[7:4] != vecs[v].b[7:4]) ? 2 : 3);
        end
        force_zero = 1'b0;

        // Random operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            ra  = 8'($urandom);
            rb  = (($urandom_range(0, 3)) == 0) ? ra : 8'($urandom);
            rop = 2'($urandom);
            rc  = 1'($urandom);
            rfz = ($urandom_range(0, 7) == 0);
            force_zero = rfz;
            ref_model(ra, rb, rop, rc, rfz, rr, re, rz, rlat);
            run_op(ra, rb, rop, rc, rr, re, rz, rlat);
        end
        force_zero = 1'b0;

        // start re-asserted in HIGH and LOW is ignored: one done pulse only.
        @(negedge clock);
        a = 8'h12; b = 8'h34; op = 2'b00; cin0 = 1'b0; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clock);
            if (i >= 3) start = 1'b0;
            if (done) begin
                ndone++;
                check("pulse_done_cycle", i, 3);
            end
        end
        check("pulse_done_count", ndone, 1);
        check("pulse_result", {24'd0, result}, 32'h46);

        // start held continuously: done every third cycle.
        @(negedge clock);
        a = 8'h12; b = 8'h34; op = 2'b00; start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            check("cont_done", {31'd0, done}, (i % 3 == 0) ? 32'd1 : 32'd0);
            if (i == 9) start = 1'b0;
        end
        check("cont_result", {24'd0, result}, 32'h46);

        // Reset during LOW aborts without a done pulse.
        @(negedge clock);
        a = 8'hF0; b = 8'h0F; op = 2'b10; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        check("abort_in_low", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", {24'd0, result}, 32'd0);
        check("abort_eq", {31'd0, eq}, 32'd0);
        check("abort_zero", {31'd0, zero}, 32'd0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu8_nibble_seq
`default_nettype wire
